fft_hdmi_fifo_wr_ctrl: RTL and testbench



---
 rtl/fft_hdmi_fifo_wr_ctrl_if.sv | 44 ++++
 rtl/fft_hdmi_fifo_wr_ctrl.sv | 100 ++++++++++
 tb/tb_fft_hdmi_fifo_wr_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fft_hdmi_fifo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_hdmi_fifo_wr_ctrl_if : write-side bus of the fft_hdmi async FIFO. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fft_hdmi_fifo_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [ADDR_WIDTH:0]   rd_ptr_gray;
   logic                  ram_wr_en;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic [ADDR_WIDTH:0]   wr_ptr_gray;
   logic                  wr_full;
   logic                  almost_full;
   logic                  wr_overflow;
`ifdef FFT_HDMI_FIFO_WR_WATER_LEVEL_EN
   logic [ADDR_WIDTH:0]   wr_water_level;

   modport master (
      input  wr_en, rd_ptr_gray,
      output ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, almost_full,
             wr_overflow, wr_water_level
   );
   modport slave (
      output wr_en, rd_ptr_gray,
      input  ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, almost_full,
             wr_overflow, wr_water_level
   );
`else
   modport master (
      input  wr_en, rd_ptr_gray,
      output ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, almost_full,
             wr_overflow
   );
   modport slave (
      output wr_en, rd_ptr_gray,
      input  ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, almost_full,
             wr_overflow
   );
`endif
endinterface

`default_nettype wire

// File: rtl/fft_hdmi_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fft_hdmi_fifo_wr_ctrl : async FIFO write pointer, full/almost-full/overflow.
// Optional macro FFT_HDMI_FIFO_WR_WATER_LEVEL_EN adds wr_water_level. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_hdmi_fifo_wr_ctrl #(
   parameter int ADDR_WIDTH      = 4,
   parameter int ALMOST_FULL_NUM = 12,
   parameter int SYNC_STAGES     = 2
) (
   input  wire logic               wr_clk,
   input  wire logic               asyn_rst,
   fft_hdmi_fifo_wr_ctrl_if.master bus
);
   localparam int            A     = ADDR_WIDTH;
   localparam logic [A:0]    C_AF  = (A+1)'(ALMOST_FULL_NUM);
   localparam logic [A:0]    C_ONE = (A+1)'(1);

   function automatic logic [A:0] bin2gray(input logic [A:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [A:0] gray2bin(input logic [A:0] g);
      logic [A:0] b;
      b[A] = g[A];
      for (int i = A - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [A:0]                     wr_ptr_bin_q,  wr_ptr_bin_d;
   logic [A:0]                     wr_ptr_gray_q, wr_ptr_gray_d;
   logic [SYNC_STAGES-1:0][A:0]    rq_sync_q,     rq_sync_d;
   logic                           wr_full_q,     wr_full_d;
   logic                           almost_full_q, almost_full_d;
   logic                           wr_overflow_q, wr_overflow_d;
   logic                           ram_wr_en_w;
   logic [A:0]                     rq_last_w;
   logic [A:0]                     rd_ptr_bin_s;
   logic [A:0]                     level_next;

   assign ram_wr_en_w = bus.wr_en & ~wr_full_q;
   assign rq_last_w   = rq_sync_q[SYNC_STAGES-1];

   always_comb begin
      wr_ptr_bin_d  = wr_ptr_bin_q + (ram_wr_en_w ? C_ONE : '0);
      wr_ptr_gray_d = bin2gray(wr_ptr_bin_d);
      // Stage 0 samples the foreign-domain pointer; the last stage is trusted.
      rq_sync_d     = {rq_sync_q[SYNC_STAGES-2:0], bus.rd_ptr_gray};
      rd_ptr_bin_s  = gray2bin(rq_last_w);
      level_next    = wr_ptr_bin_d - rd_ptr_bin_s;
      wr_full_d     = (wr_ptr_gray_d == {~rq_last_w[A:A-1], rq_last_w[A-2:0]});
      almost_full_d = (level_next >= C_AF);
      wr_overflow_d = bus.wr_en & wr_full_q;
   end

   always_ff @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         wr_ptr_bin_q  <= '0;
         wr_ptr_gray_q <= '0;
         rq_sync_q     <= '0;
         wr_full_q     <= 1'b0;
         almost_full_q <= 1'b0;
         wr_overflow_q <= 1'b0;
      end else begin
         wr_ptr_bin_q  <= wr_ptr_bin_d;
         wr_ptr_gray_q <= wr_ptr_gray_d;
         rq_sync_q     <= rq_sync_d;
         wr_full_q     <= wr_full_d;
         almost_full_q <= almost_full_d;
         wr_overflow_q <= wr_overflow_d;
      end
   end

`ifdef FFT_HDMI_FIFO_WR_WATER_LEVEL_EN
   logic [A:0] wr_water_level_q;

   always_ff @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         wr_water_level_q <= '0;
      end else begin
         wr_water_level_q <= level_next;
      end
   end

   assign bus.wr_water_level = wr_water_level_q;
`endif

   assign bus.ram_wr_en   = ram_wr_en_w;
   assign bus.ram_wr_addr = wr_ptr_bin_q[A-1:0];
   assign bus.wr_ptr_gray = wr_ptr_gray_q;
   assign bus.wr_full     = wr_full_q;
   assign bus.almost_full = almost_full_q;
   assign bus.wr_overflow = wr_overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_hdmi_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_hdmi_fifo_wr_ctrl : directed scoreboard bench for the FIFO write side.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_hdmi_fifo_wr_ctrl;
   logic wr_clk   = 1'b0;
   logic asyn_rst = 1'b1;
   int   vectors  = 0;
   int   errs     = 0;

   logic [4:0] m_wr = '0;
   logic [3:0] sb_q[$];

   fft_hdmi_fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

   fft_hdmi_fifo_wr_ctrl #(
      .ADDR_WIDTH      (4),
      .ALMOST_FULL_NUM (12),
      .SYNC_STAGES     (2)
   ) dut (
      .wr_clk   (wr_clk),
      .asyn_rst (asyn_rst),
      .bus      (bus)
   );

   always #5 wr_clk = ~wr_clk;

   function automatic logic [4:0] g(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One write-clock cycle: drive at negedge, check the combinational RAM
   // port before the edge, return just after the edge.
   task automatic drive(input logic en, input logic exp_accept);
      logic [3:0] exp_addr;
      @(negedge wr_clk);
      bus.wr_en = en;
      if (exp_accept) begin
         sb_q.push_back(m_wr[3:0]);
         m_wr = m_wr + 5'd1;
      end
      #1;
      chk("ram_wr_en", bus.ram_wr_en, exp_accept);
      if (exp_accept) begin
         exp_addr = sb_q.pop_front();
         chk("ram_wr_addr", bus.ram_wr_addr, exp_addr);
      end
      @(posedge wr_clk);
      #1;
   endtask

   task automatic reset_pulse();
      bus.wr_en = 1'b0;
      asyn_rst  = 1'b1;
      #7;
      @(negedge wr_clk);
      asyn_rst  = 1'b0;
      m_wr      = '0;
      sb_q.delete();
   endtask

   initial begin
      logic [4:0] prev_gray;
      logic [4:0] t;
      bus.wr_en       = 1'b0;
      bus.rd_ptr_gray = '0;

      // Reset state
      #12;
      chk("rst_ram_wr_en",   bus.ram_wr_en,   0);
      chk("rst_ram_wr_addr", bus.ram_wr_addr, 0);
      chk("rst_wr_ptr_gray", bus.wr_ptr_gray, 0);
      chk("rst_wr_full",     bus.wr_full,     0);
      chk("rst_almost_full", bus.almost_full, 0);
      chk("rst_wr_overflow", bus.wr_overflow, 0);
`ifdef FFT_HDMI_FIFO_WR_WATER_LEVEL_EN
      chk("rst_water_level", bus.wr_water_level, 0);
`endif
      @(negedge wr_clk);
      asyn_rst = 1'b0;

      // Fill
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1);
         chk("fill_almost_full", bus.almost_full, (i >= 11));
         chk("fill_wr_full",     bus.wr_full,     (i == 15));
      end
      chk("fill_wr_ptr_gray", bus.wr_ptr_gray, 5'b11000);
`ifdef FFT_HDMI_FIFO_WR_WATER_LEVEL_EN
      chk("fill_water_level", bus.wr_water_level, 16);
`endif

      // Overflow
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0);
         chk("ovf_pulse",       bus.wr_overflow, 1);
         chk("ovf_wr_full",     bus.wr_full,     1);
         chk("ovf_ram_wr_addr", bus.ram_wr_addr, 0);
         chk("ovf_wr_ptr_gray", bus.wr_ptr_gray, 5'b11000);
      end
      drive(1'b0, 1'b0);
      chk("ovf_pulse_end", bus.wr_overflow, 0);

      // Release: read pointer advances by one
      bus.rd_ptr_gray = 5'b00001;
      drive(1'b0, 1'b0);
      chk("rel_full_e1", bus.wr_full, 1);
      drive(1'b0, 1'b0);
      chk("rel_full_e2", bus.wr_full, 1);
      drive(1'b0, 1'b0);
      chk("rel_full_e3",   bus.wr_full,     0);
      chk("rel_almost_e3", bus.almost_full, 1);
      drive(1'b1, 1'b1);
      chk("rel_refull",       bus.wr_full,     1);
      chk("rel_wr_ptr_gray",  bus.wr_ptr_gray, 5'b11001);

      // Reset mid-operation after 9 writes
      bus.rd_ptr_gray = '0;
      reset_pulse();
      for (int i = 0; i < 9; i++) drive(1'b1, 1'b1);
      chk("pre_rst_addr", bus.ram_wr_addr, 9);
      bus.wr_en = 1'b0;
      #2;
      asyn_rst = 1'b1;
      #1;
      chk("mid_rst_ram_wr_addr", bus.ram_wr_addr, 0);
      chk("mid_rst_wr_ptr_gray", bus.wr_ptr_gray, 0);
      chk("mid_rst_almost_full", bus.almost_full, 0);
      chk("mid_rst_wr_full",     bus.wr_full,     0);
      chk("mid_rst_ram_wr_en",   bus.ram_wr_en,   0);
      reset_pulse();
      drive(1'b1, 1'b1);
      chk("post_rst_gray", bus.wr_ptr_gray, 5'b00001);

      // Wrap with the reader tracking behind the writer
      reset_pulse();
      for (int k = 0; k < 40; k++) begin
         t = (k >= 1) ? 5'(k - 1) : 5'd0;
         bus.rd_ptr_gray = g(t);
         prev_gray = bus.wr_ptr_gray;
         drive(1'b1, 1'b1);
         chk("wrap_gray",        bus.wr_ptr_gray, g(m_wr));
         chk("wrap_gray_step",   $countones(prev_gray ^ bus.wr_ptr_gray), 1);
         chk("wrap_wr_full",     bus.wr_full,     0);
         chk("wrap_almost_full", bus.almost_full, 0);
`ifdef FFT_HDMI_FIFO_WR_WATER_LEVEL_EN
         if (k >= 4) chk("wrap_water_level", bus.wr_water_level, 4);
`endif
      end
      bus.wr_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

`default_nettype wire
